// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W    = 6;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned FCNT_W     = 3;

    // Bit positions inside the stall vector
    localparam int unsigned STALL_BIT_PC  = 0;
    localparam int unsigned STALL_BIT_IF  = 1;
    localparam int unsigned STALL_BIT_ID  = 2;
    localparam int unsigned STALL_BIT_EX  = 3;
    localparam int unsigned STALL_BIT_MEM = 4;
    localparam int unsigned STALL_BIT_WB  = 5;

    // A stalled stage also holds every stage in front of it
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush bundle between the pipeline controller and the core datapath.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic                  stallreq_id_i;
    logic                  stallreq_ex_i;
    logic                  stallreq_mem_i;
    logic                  ex_is_load_i;
    logic [REG_ADDR_W-1:0] ex_wd_i;
    logic                  id_reg1_read_i;
    logic [REG_ADDR_W-1:0] id_reg1_addr_i;
    logic                  id_reg2_read_i;
    logic [REG_ADDR_W-1:0] id_reg2_addr_i;
    logic                  flush_req_i;
    logic [PC_W-1:0]       flush_pc_i;
    logic [STALL_W-1:0]    stall_o;
    logic                  flush_o;
    logic                  flush_ack_o;
    logic [PC_W-1:0]       new_pc_o;
    logic [CNT_W-1:0]      stall_cycles_o;
    logic [CNT_W-1:0]      flush_count_o;
    logic                  stall_timeout_o;

    // Controller side
    modport master (
        input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  ex_is_load_i, ex_wd_i,
        input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        input  flush_req_i, flush_pc_i,
        output stall_o, flush_o, flush_ack_o, new_pc_o,
        output stall_cycles_o, flush_count_o, stall_timeout_o
    );

    // Datapath side
    modport slave (
        output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output ex_is_load_i, ex_wd_i,
        output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
        output flush_req_i, flush_pc_i,
        input  stall_o, flush_o, flush_ack_o, new_pc_o,
        input  stall_cycles_o, flush_count_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up counter that sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment unless already saturated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merging, load-use detection, flush sequencing,
// statistics and stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDOG_LIMIT   = 1024,
    parameter int unsigned CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_if.master     bus
);

    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

    state_e              state;
    state_e              state_nxt;
    logic                hazard_c;
    logic                accept_c;
    logic                stalled_c;
    logic [STALL_W-1:0]  stall_c;
    logic [FCNT_W-1:0]   fcnt;
    logic                flush_q;
    logic                ack_q;
    logic [PC_W-1:0]     pc_q;
    logic [WDOG_W-1:0]   wdog;
    logic                timeout_q;

    // Load-use: ID needs a register the load in EX has not produced yet
    always_comb begin
        hazard_c = bus.ex_is_load_i && (bus.ex_wd_i != '0) &&
                   ((bus.id_reg1_read_i && (bus.id_reg1_addr_i == bus.ex_wd_i)) ||
                    (bus.id_reg2_read_i && (bus.id_reg2_addr_i == bus.ex_wd_i)));
    end

    // Next state, stall priority and flush acceptance
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        stall_c   = STALL_NONE;

        if (state != ST_FLUSH) begin
            if (bus.stallreq_mem_i)                  stall_c = STALL_MEM;
            else if (bus.stallreq_ex_i)              stall_c = STALL_EX;
            else if (bus.stallreq_id_i || hazard_c)  stall_c = STALL_ID;
        end

        case (state)
            ST_RUN: begin
                if (bus.flush_req_i) begin
                    if (bus.stallreq_mem_i) begin
                        state_nxt = ST_WAIT_MEM;
                    end else begin
                        state_nxt = ST_FLUSH;
                        accept_c  = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (!bus.stallreq_mem_i) begin
                    state_nxt = ST_FLUSH;
                    accept_c  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fcnt == '0) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign stalled_c = (stall_c != STALL_NONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    // Flush outputs, target latch and flush-length down counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q <= 1'b0;
            ack_q   <= 1'b0;
            pc_q    <= '0;
            fcnt    <= '0;
        end else begin
            flush_q <= (state_nxt == ST_FLUSH);
            ack_q   <= accept_c;
            if (accept_c) begin
                pc_q <= bus.flush_pc_i;
                fcnt <= FCNT_W'(FLUSH_CYCLES - 1);
            end else if ((state == ST_FLUSH) && (fcnt != '0)) begin
                fcnt <= fcnt - FCNT_W'(1);
            end
        end
    end

    // Watchdog: length of the current uninterrupted stall, sticky timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else if (stalled_c) begin
            if (wdog != WDOG_W'(WDOG_LIMIT)) wdog <= wdog + WDOG_W'(1);
            if (wdog >= WDOG_W'(WDOG_LIMIT - 1)) timeout_q <= 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stalled_c),
        .count (bus.stall_cycles_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept_c),
        .count (bus.flush_count_o)
    );

    assign bus.stall_o         = stall_c;
    assign bus.flush_o         = flush_q;
    assign bus.flush_ack_o     = ack_q;
    assign bus.new_pc_o        = pc_q;
    assign bus.stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned FC = 3;
    localparam int unsigned WL = 8;
    localparam int unsigned CW = 8;
    localparam int         CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_ctrl_if #(.CNT_W(CW)) bus();

    pipe_ctrl #(.FLUSH_CYCLES(FC), .WDOG_LIMIT(WL), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int          m_flush_left;
    bit          m_pending;
    bit          m_ack;
    logic [31:0] m_pc;
    int          m_stall_cnt;
    int          m_flush_cnt;
    int          m_run;
    bit          m_timeout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_flush_left = 0;
        m_pending    = 0;
        m_ack        = 0;
        m_pc         = '0;
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
        m_run        = 0;
        m_timeout    = 0;
    endtask

    function automatic logic [5:0] m_stall();
        bit haz;
        haz = bus.ex_is_load_i && (bus.ex_wd_i != 0) &&
              ((bus.id_reg1_read_i && bus.id_reg1_addr_i == bus.ex_wd_i) ||
               (bus.id_reg2_read_i && bus.id_reg2_addr_i == bus.ex_wd_i));
        if (m_flush_left > 0)                  return 6'b000000;
        if (bus.stallreq_mem_i)                return 6'b011111;
        if (bus.stallreq_ex_i)                 return 6'b001111;
        if (bus.stallreq_id_i || haz)          return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic check_outputs();
        check("stall",      32'(bus.stall_o),         32'(m_stall()));
        check("flush",      32'(bus.flush_o),         32'(m_flush_left > 0));
        check("ack",        32'(bus.flush_ack_o),     32'(m_ack));
        check("new_pc",     bus.new_pc_o,             m_pc);
        check("stall_cnt",  32'(bus.stall_cycles_o),  32'(m_stall_cnt));
        check("flush_cnt",  32'(bus.flush_count_o),   32'(m_flush_cnt));
        check("timeout",    32'(bus.stall_timeout_o), 32'(m_timeout));
    endtask

    // Check current cycle, advance one clock, update model; ends at negedge
    task automatic tick();
        bit stalled;
        #1;
        check_outputs();
        stalled = (m_stall() != 0);
        @(posedge clk);
        if (stalled && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (stalled) begin
            m_run++;
            if (m_run >= WL) m_timeout = 1;
        end else begin
            m_run = 0;
        end
        m_ack = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_pending || bus.flush_req_i) begin
            if (bus.stallreq_mem_i) begin
                m_pending = 1;
            end else begin
                m_pending    = 0;
                m_flush_left = FC;
                m_ack        = 1;
                m_pc         = bus.flush_pc_i;
                if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit id, input bit ex, input bit mem, input bit ld,
                          input logic [4:0] wd, input bit r1, input logic [4:0] a1,
                          input bit r2, input logic [4:0] a2, input bit req,
                          input logic [31:0] pc);
        bus.stallreq_id_i  = id;
        bus.stallreq_ex_i  = ex;
        bus.stallreq_mem_i = mem;
        bus.ex_is_load_i   = ld;
        bus.ex_wd_i        = wd;
        bus.id_reg1_read_i = r1;
        bus.id_reg1_addr_i = a1;
        bus.id_reg2_read_i = r2;
        bus.id_reg2_addr_i = a2;
        bus.flush_req_i    = req;
        bus.flush_pc_i     = pc;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b0;
        m_reset();
        #3;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // 1: idle
        for (int i = 0; i < 100; i++) tick();
        check("idle_stall_cnt", 32'(bus.stall_cycles_o), 32'd0);

        // 2: load-use hazard, then r0 never hazards
        set_in(0, 0, 0, 1, 5'd5, 0, 5'd0, 1, 5'd5, 0, 32'h0);
        #1 check("hazard_stall", 32'(bus.stall_o), 32'b000111);
        tick();
        set_in(0, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 32'h0);
        #1 check("r0_no_hazard", 32'(bus.stall_o), 32'd0);
        tick();

        // 3: priority
        set_in(1, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        #1 check("prio_mem", 32'(bus.stall_o), 32'b011111);
        tick(); tick();
        bus.stallreq_mem_i = 0;
        #1 check("prio_ex", 32'(bus.stall_o), 32'b001111);
        tick();
        check("stall_cnt_3", 32'(bus.stall_cycles_o), 32'd4);

        // 4: flush without mem stall
        set_in(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'hBFC00380);
        tick();
        bus.flush_req_i = 0;
        bus.stallreq_ex_i = 1;
        #1;
        check("flush_rise", 32'(bus.flush_o), 32'd1);
        check("flush_ack", 32'(bus.flush_ack_o), 32'd1);
        check("flush_pc", bus.new_pc_o, 32'hBFC00380);
        check("flush_stall0", 32'(bus.stall_o), 32'd0);
        check("flush_cnt1", 32'(bus.flush_count_o), 32'd1);
        for (int i = 0; i < FC + 1; i++) tick();
        check("flush_done", 32'(bus.flush_o), 32'd0);
        idle();
        tick();

        // 5: flush deferred behind a memory stall
        set_in(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'h80001000);
        for (int i = 0; i < 4; i++) begin
            #1 check("wait_mem_stall", 32'(bus.stall_o), 32'b011111);
            tick();
        end
        bus.stallreq_mem_i = 0;
        tick();
        bus.flush_req_i = 0;
        #1 check("wait_mem_flush", 32'(bus.flush_o), 32'd1);
        for (int i = 0; i < FC + 1; i++) tick();

        // 6: watchdog, then reset in the middle of a flush
        do_reset();
        set_in(0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        check("wdog_not_yet", 32'(bus.stall_timeout_o), 32'd0);
        tick();
        check("wdog_set", 32'(bus.stall_timeout_o), 32'd1);
        idle();
        for (int i = 0; i < 3; i++) tick();
        check("wdog_sticky", 32'(bus.stall_timeout_o), 32'd1);
        set_in(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'h12345678);
        tick();
        idle();
        tick();
        rst = 1'b0;
        #1;
        check("rst_flush", 32'(bus.flush_o), 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cycles_o), 32'd0);
        check("rst_flush_cnt", 32'(bus.flush_count_o), 32'd0);
        check("rst_timeout", 32'(bus.stall_timeout_o), 32'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            bus.stallreq_id_i  = ($urandom_range(0, 5) == 0);
            bus.stallreq_ex_i  = ($urandom_range(0, 7) == 0);
            bus.stallreq_mem_i = ($urandom_range(0, 3) == 0);
            bus.ex_is_load_i   = ($urandom_range(0, 1) == 0);
            bus.ex_wd_i        = 5'($urandom_range(0, 7));
            bus.id_reg1_read_i = ($urandom_range(0, 1) == 0);
            bus.id_reg1_addr_i = 5'($urandom_range(0, 7));
            bus.id_reg2_read_i = ($urandom_range(0, 1) == 0);
            bus.id_reg2_addr_i = 5'($urandom_range(0, 7));
            bus.flush_req_i    = m_pending ? 1'b1 : ($urandom_range(0, 5) == 0);
            bus.flush_pc_i     = $urandom;
            if (i == 3000) do_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
